acumulador_frame: RTL and testbench

Parametrised signed accumulator with add/subtract/load/clear opcodes, optional saturation, sticky overflow and frame counting. It is the next generation of the team's 4-bit accumulator. Widths are configurable and the accumulator width is independent of the operand width. After a programmable number of samples it closes a frame and holds the result with a `done` flag. It sits between a sample source that strobes `en` and a consumer that reads `out` when `done` is high.

---
 rtl/acumulador_frame.sv | 105 ++++++++++
 tb/tb_acumulador_frame.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_frame.sv
// Signed frame accumulator: ADD/SUB/LOAD/CLR opcodes, optional saturation, sticky overflow,
// and a sample counter that closes a frame after len samples and holds the result.
module acumulador_frame #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned ACC_W = 8,
    parameter int unsigned CNT_W = 4,
    parameter bit          SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [IN_W-1:0]  A,
    input  logic [CNT_W-1:0] len,
    output logic [ACC_W-1:0] out,
    output logic             ovf,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [1:0] OpAdd  = 2'b00;
    localparam logic [1:0] OpSub  = 2'b01;
    localparam logic [1:0] OpLoad = 2'b10;
    localparam logic [1:0] OpClr  = 2'b11;

    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   out_q, out_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ACC_W:0]     a_ext;
    logic [ACC_W:0]     base;
    logic [ACC_W:0]     sum;
    logic               sum_ovf;
    logic [ACC_W-1:0]   sum_res;
    logic               fresh;
    logic [CNT_W:0]     cnt_next;
    logic               frame_end;

    always_comb begin
        a_ext   = {{(ACC_W + 1 - IN_W){A[IN_W-1]}}, A};
        fresh   = (state_q == StDone);
        // A sample accepted in DONE starts a new frame from zero, not from the held result.
        base    = fresh ? '0 : {out_q[ACC_W-1], out_q};
        sum     = (op == OpSub) ? (base - a_ext) : (base + a_ext);
        sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        if (sum_ovf && SAT) begin
            sum_res = sum[ACC_W] ? AccMin : AccMax;
        end else begin
            sum_res = sum[ACC_W-1:0];
        end

        cnt_next  = fresh ? (CNT_W + 1)'(1) : ({1'b0, cnt_q} + (CNT_W + 1)'(1));
        frame_end = (len != '0) && (cnt_next >= {1'b0, len});
    end

    always_comb begin
        out_d   = out_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (en) begin
            if (op == OpClr) begin
                out_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = '0;
                state_d = StRun;
            end else begin
                if (op == OpLoad) begin
                    out_d = a_ext[ACC_W-1:0];
                end else begin
                    out_d = sum_res;
                end
                ovf_d   = (fresh ? 1'b0 : ovf_q) | (sum_ovf && (op != OpLoad));
                cnt_d   = cnt_next[CNT_W] ? '1 : cnt_next[CNT_W-1:0];
                state_d = frame_end ? StDone : StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            out_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StRun;
        end else begin
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign out  = out_q;
    assign ovf  = ovf_q;
    assign cnt  = cnt_q;
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_acumulador_frame.sv
// Directed bench for acumulador_frame: a saturating and a wrapping instance share stimulus and
// are checked every cycle against an integer model, plus literal expectations from the test plan.
module tb_acumulador_frame;

    localparam int IN_W  = 4;
    localparam int ACC_W = 8;
    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
    localparam int MINV  = -(1 << (ACC_W - 1));
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] LOAD = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    logic             clk;
    logic             clr_n;
    logic             en;
    logic [1:0]       op;
    logic [IN_W-1:0]  A;
    logic [CNT_W-1:0] len;

    logic [ACC_W-1:0] out_s, out_w;
    logic             ovf_s, ovf_w, done_s, done_w;
    logic [CNT_W-1:0] cnt_s, cnt_w;

    acumulador_frame #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT(1'b1)) u_sat (
        .clk(clk), .clr_n(clr_n), .en(en), .op(op), .A(A), .len(len),
        .out(out_s), .ovf(ovf_s), .cnt(cnt_s), .done(done_s)
    );

    acumulador_frame #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT(1'b0)) u_wrap (
        .clk(clk), .clr_n(clr_n), .en(en), .op(op), .A(A), .len(len),
        .out(out_w), .ovf(ovf_w), .cnt(cnt_w), .done(done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int acc;
        bit ovf;
        int cnt;
        bit done;
    } mstate_t;

    mstate_t m[2];  // index 0: wrapping instance, 1: saturating instance
    bit      m_valid = 1'b0;
    int      n_checks = 0;
    int      n_err = 0;

    function automatic mstate_t model_next(mstate_t s, bit sat);
        mstate_t n;
        int a, base, r, newcnt;
        bit ov;
        n = s;
        if (!clr_n) begin
            n.acc = 0; n.ovf = 0; n.cnt = 0; n.done = 0;
        end else if (en) begin
            if (op == CLR) begin
                n.acc = 0; n.ovf = 0; n.cnt = 0; n.done = 0;
            end else begin
                a    = $signed(A);
                base = s.done ? 0 : s.acc;
                if (op == LOAD) r = a;
                else if (op == ADD) r = base + a;
                else r = base - a;
                ov = (r > MAXV) || (r < MINV);
                if (ov) begin
                    if (sat) r = (r > MAXV) ? MAXV : MINV;
                    else if (r > MAXV) r = r - (1 << ACC_W);
                    else r = r + (1 << ACC_W);
                end
                newcnt = s.done ? 1 : s.cnt + 1;
                n.acc  = r;
                n.ovf  = (s.done ? 1'b0 : s.ovf) | ov;
                n.cnt  = (newcnt > CMAX) ? CMAX : newcnt;
                n.done = (len != 0) && (newcnt >= int'(len));
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m[0] <= model_next(m[0], 1'b0);
        m[1] <= model_next(m[1], 1'b1);
        if (!clr_n) m_valid <= 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model.wrap.out", int'($signed(out_w)), m[0].acc);
            chk("model.wrap.ovf", int'(ovf_w), int'(m[0].ovf));
            chk("model.wrap.cnt", int'(cnt_w), m[0].cnt);
            chk("model.wrap.done", int'(done_w), int'(m[0].done));
            chk("model.sat.out", int'($signed(out_s)), m[1].acc);
            chk("model.sat.ovf", int'(ovf_s), int'(m[1].ovf));
            chk("model.sat.cnt", int'(cnt_s), m[1].cnt);
            chk("model.sat.done", int'(done_s), int'(m[1].done));
        end
    end

    task automatic cyc(input logic e, input logic [1:0] o, input int a);
        logic [31:0] av;
        av  = a;
        en  = e;
        op  = o;
        A   = av[IN_W-1:0];
        @(posedge clk);
        @(negedge clk);
    endtask

    // Literal expectation on one instance: sel 1 = saturating, 0 = wrapping.
    task automatic lit(input string name, input bit sel, input int e_out, input int e_cnt,
                       input int e_ovf, input int e_done);
        if (sel) begin
            chk({name, ".out"}, int'($signed(out_s)), e_out);
            chk({name, ".cnt"}, int'(cnt_s), e_cnt);
            chk({name, ".ovf"}, int'(ovf_s), e_ovf);
            chk({name, ".done"}, int'(done_s), e_done);
        end else begin
            chk({name, ".out"}, int'($signed(out_w)), e_out);
            chk({name, ".cnt"}, int'(cnt_w), e_cnt);
            chk({name, ".ovf"}, int'(ovf_w), e_ovf);
            chk({name, ".done"}, int'(done_w), e_done);
        end
    endtask

    initial begin
        clr_n = 1'b0;
        en    = 1'b1;
        op    = ADD;
        A     = 4'd3;
        len   = 4'd3;

        // Reset overrides en/op, then release with en low.
        repeat (5) cyc(1'b1, ADD, 3);
        lit("reset", 1'b1, 0, 0, 0, 0);
        clr_n = 1'b1;
        cyc(1'b0, ADD, 3);
        cyc(1'b0, ADD, 3);
        lit("hold", 1'b1, 0, 0, 0, 0);

        // Frame of 3.
        cyc(1'b1, ADD, 2);  lit("f3.add2", 1'b1, 2, 1, 0, 0);
        cyc(1'b1, ADD, 3);  lit("f3.add3", 1'b1, 5, 2, 0, 0);
        cyc(1'b1, SUB, 1);  lit("f3.sub1", 1'b1, 4, 3, 0, 1);
        cyc(1'b0, ADD, 7);
        cyc(1'b0, SUB, 7);  lit("f3.held", 1'b1, 4, 3, 0, 1);
        cyc(1'b1, ADD, 5);  lit("f3.new", 1'b1, 5, 1, 0, 0);

        // Free-run: saturation on u_sat, wrap on u_wrap.
        cyc(1'b1, CLR, 0);
        len = 4'd0;
        cyc(1'b1, LOAD, 7);
        repeat (17) cyc(1'b1, ADD, 7);
        lit("sat.126", 1'b1, 126, 15, 0, 0);
        cyc(1'b1, ADD, 7);
        lit("sat.clamp", 1'b1, 127, 15, 1, 0);
        lit("wrap.load18", 1'b0, -123, 15, 1, 0);
        cyc(1'b1, SUB, 7);
        lit("sat.sub", 1'b1, 120, 15, 1, 0);
        cyc(1'b1, CLR, 0);
        lit("sat.clr", 1'b1, 0, 0, 0, 0);

        repeat (17) cyc(1'b1, ADD, 7);
        lit("wrap.119", 1'b0, 119, 15, 0, 0);
        cyc(1'b1, ADD, 7);
        lit("wrap.126", 1'b0, 126, 15, 0, 0);
        cyc(1'b1, ADD, 7);
        lit("wrap.neg", 1'b0, -123, 15, 1, 0);
        lit("wrap.satinst", 1'b1, 127, 15, 1, 0);

        // Negative clamp.
        cyc(1'b1, CLR, 0);
        cyc(1'b1, LOAD, -8);
        repeat (17) cyc(1'b1, SUB, 7);
        lit("neg.-127", 1'b1, -127, 15, 0, 0);
        cyc(1'b1, SUB, 7);
        lit("neg.clamp", 1'b1, -128, 15, 1, 0);
        cyc(1'b1, SUB, 7);
        lit("neg.stay", 1'b1, -128, 15, 1, 0);

        // Mid-frame len change, reset in DONE, CLR then LOAD in DONE.
        cyc(1'b1, CLR, 0);
        len = 4'd4;
        cyc(1'b1, ADD, 1);
        cyc(1'b1, ADD, 1);
        lit("mid.two", 1'b1, 2, 2, 0, 0);
        len = 4'd1;
        cyc(1'b1, ADD, 1);
        lit("mid.close", 1'b1, 3, 3, 0, 1);
        clr_n = 1'b0;
        cyc(1'b0, ADD, 1);
        clr_n = 1'b1;
        lit("mid.reset", 1'b1, 0, 0, 0, 0);
        cyc(1'b1, ADD, 1);
        lit("mid.len1", 1'b1, 1, 1, 0, 1);
        cyc(1'b1, CLR, 0);
        lit("mid.clr", 1'b1, 0, 0, 0, 0);
        cyc(1'b1, LOAD, -3);
        lit("mid.load", 1'b1, -3, 1, 0, 1);
        cyc(1'b1, SUB, 2);
        lit("mid.newframe", 1'b1, -2, 1, 0, 1);
        cyc(1'b0, ADD, 7);
        lit("mid.hold", 1'b1, -2, 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
